fb_pixel_writer: RTL and testbench
==================================

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-003 SHALL have parameter ADR_W, default 17, framebuffer word-address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel write request.
- pix_ready  out  1  writer can accept a pixel.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- pix_color  in  8  palette index.
- clr_start  in  1  request a full-frame fill.
- clr_color  in  8  fill palette index.
- clr_done  out  1  one-cycle pulse when the fill completes.
- busy  out  1  FSM is not in IDLE.
- drop_cnt  out  16  count of out-of-range pixels.
- ram_adr  out  ADR_W  framebuffer word address.
- ram_we  out  1  1 = write, 0 = read.
- ram_wdat  out  32  write data.
- ram_rdat  in  32  read data; synchronous RAM, valid the cycle after a read edge.

Function
REQ-005 SHALL store 4 pixels per word at address y*(H_VIS/4)+x[9:2].
- Byte lane: x[1:0]=0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
REQ-006 SHALL implement FSM states IDLE, RD, MRG, WR, CLR.
REQ-007 SHALL drive pix_ready = (state==IDLE) && !clr_start; a pixel is accepted on a rising edge with pix_valid && pix_ready.
REQ-008 SHALL on accept of an in-range pixel:
- Register ram_adr and set ram_we=0, then go to RD.
- RD goes to MRG.
- In MRG, register ram_wdat = ram_rdat with only the addressed byte replaced, set ram_we=1, then go to WR.
- WR sets ram_we=0 and returns to IDLE.
- RAM write occurs 3 edges after accept; at most 1 pixel per 4 cycles.
REQ-009 SHALL treat x>=H_VIS or y>=V_VIS as out of range:
- Accept the pixel, make no RAM access, stay in IDLE.
- Increment drop_cnt, saturating at 16'hFFFF.
REQ-010 SHALL leave pix_x/pix_y/pix_color unsampled outside the accept edge; the latched pixel is used throughout RD/MRG/WR.
REQ-011 SHALL give clr_start priority over pix_valid when both are seen in IDLE; that pixel is not accepted.
REQ-012 SHALL ignore clr_start outside IDLE (no queuing).
REQ-013 SHALL never let ram_adr exceed H_VIS*V_VIS/4-1 while ram_we=1.
REQ-014 SHALL drive busy = (state!=IDLE).

Reset
REQ-015 SHALL, while rst_n=0, force:
- state=IDLE, pix_ready=1, ram_we=0, ram_adr=0, ram_wdat=0.
- busy=0, clr_done=0, drop_cnt=0.
REQ-016 SHALL on reset mid-operation (RD/MRG/WR/CLR):
- Drop ram_we immediately (asynchronously) and abandon the pixel or fill.
- Perform no RAM write after rst_n rises until a new request.

Configuration
REQ-017 SHALL gate the fill feature with macro FB_PIXEL_WRITER_CLEAR_EN.
- Defined, on clr_start in IDLE: latch clr_color and enter CLR.
- In CLR: write {4{clr_color}} to addresses 0..H_VIS*V_VIS/4-1, one word per cycle, ram_we=1 throughout.
- After the last word: return to IDLE and pulse clr_done for 1 cycle. Fill takes 76800 cycles at default parameters.
- Undefined: CLR state absent, clr_start and clr_color ignored, pix_ready = (state==IDLE), clr_done tied 0.

Verification
REQ-018 Memory preloaded with 0x00010203; write x=5,y=0,color=0xAA -> one write at ram_adr=1, ram_wdat=0x00AA0203, exactly 3 edges after accept.
REQ-019 Back-to-back valid pixels (0,1,0x11),(3,1,0x44) -> ready low 3 cycles between accepts; word 160 = 0x11xxxx44, other bytes preserved.
REQ-020 Pixel (640,0) then (0,480) -> no RAM write, drop_cnt=2; drive 65537 drops -> drop_cnt=0xFFFF.
REQ-021 CLEAR_EN defined, clr_start and pix_valid together with clr_color=0x3C:
- Pixel not accepted; 76800 consecutive writes of 0x3C3C3C3C at addresses 0..76799.
- clr_done pulses once; busy deasserts on the same edge.
REQ-022 rst_n low during MRG, and separately at fill word 1000 -> ram_we=0 immediately, no further writes, all outputs at reset values; next pixel works normally.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: read-modify-write pixel plotter into a 4-pixel/word framebuffer.
// Optional full-frame fill is built when FB_PIXEL_WRITER_CLEAR_EN is defined.
module fb_pixel_writer #(
   parameter int H_VIS = 640,
   parameter int V_VIS = 480,
   parameter int ADR_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic [9:0]       pix_x,
   input  logic [9:0]       pix_y,
   input  logic [7:0]       pix_color,
   input  logic             clr_start,
   input  logic [7:0]       clr_color,
   output logic             clr_done,
   output logic             busy,
   output logic [15:0]      drop_cnt,
   output logic [ADR_W-1:0] ram_adr,
   output logic             ram_we,
   output logic [31:0]      ram_wdat,
   input  logic [31:0]      ram_rdat
);

   localparam int WPL    = H_VIS / 4;
   localparam int NWORDS = H_VIS * V_VIS / 4;
   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NWORDS - 1);

`ifdef FB_PIXEL_WRITER_CLEAR_EN
   typedef enum logic [2:0] {IDLE, RD, MRG, WR, CLR} state_t;
`else
   typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_t;
`endif

   state_t           state_q, state_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic             we_q, we_d;
   logic [31:0]      wdat_q, wdat_d;
   logic [1:0]       lane_q, lane_d;
   logic [7:0]       color_q, color_d;
   logic [15:0]      drop_q, drop_d;
   logic             accept;
   logic             in_range;
   logic [31:0]      merged;

`ifdef FB_PIXEL_WRITER_CLEAR_EN
   logic done_q, done_d;

   assign pix_ready = (state_q == IDLE) && !clr_start;
   assign clr_done  = done_q;
`else
   logic unused_clr;

   assign pix_ready  = (state_q == IDLE);
   assign clr_done   = 1'b0;
   assign unused_clr = ^{clr_start, clr_color};
`endif

   assign accept   = pix_valid && pix_ready;
   assign in_range = (32'(pix_x) < 32'(H_VIS)) && (32'(pix_y) < 32'(V_VIS));
   assign busy     = (state_q != IDLE);
   assign drop_cnt = drop_q;
   assign ram_adr  = adr_q;
   assign ram_we   = we_q;
   assign ram_wdat = wdat_q;

   // Byte lane 0 is the leftmost pixel and lives in the top byte.
   always_comb begin
      merged = ram_rdat;
      unique case (lane_q)
         2'd0: merged[31:24] = color_q;
         2'd1: merged[23:16] = color_q;
         2'd2: merged[15:8]  = color_q;
         2'd3: merged[7:0]   = color_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      lane_d  = lane_q;
      color_d = color_q;
      drop_d  = drop_q;
`ifdef FB_PIXEL_WRITER_CLEAR_EN
      done_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef FB_PIXEL_WRITER_CLEAR_EN
            if (clr_start) begin
               adr_d   = '0;
               wdat_d  = {4{clr_color}};
               we_d    = 1'b1;
               state_d = CLR;
            end else
`endif
            if (accept) begin
               if (in_range) begin
                  adr_d   = ADR_W'(32'(pix_y) * 32'(WPL)
                                   + 32'(pix_x[9:2]));
                  we_d    = 1'b0;
                  lane_d  = pix_x[1:0];
                  color_d = pix_color;
                  state_d = RD;
               end else if (drop_q != 16'hFFFF) begin
                  drop_d = drop_q + 16'd1;
               end
            end
         end
         RD: begin
            state_d = MRG;
         end
         MRG: begin
            wdat_d  = merged;
            we_d    = 1'b1;
            state_d = WR;
         end
         WR: begin
            we_d    = 1'b0;
            state_d = IDLE;
         end
`ifdef FB_PIXEL_WRITER_CLEAR_EN
         CLR: begin
            if (adr_q == LAST_ADR) begin
               we_d    = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               adr_d = adr_q + ADR_W'(1);
            end
         end
`endif
         default: begin
            we_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         lane_q  <= '0;
         color_q <= '0;
         drop_q  <= '0;
`ifdef FB_PIXEL_WRITER_CLEAR_EN
         done_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         lane_q  <= lane_d;
         color_q <= color_d;
         drop_q  <= drop_d;
`ifdef FB_PIXEL_WRITER_CLEAR_EN
         done_q  <= done_d;
`endif
      end
   end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: vector table, corner sequences and a random run
// against a word-level framebuffer model.
module tb_fb_pixel_writer;

   localparam int H = 640;
   localparam int V = 480;
   localparam int NW = H * V / 4;
   localparam logic [31:0] PRE = 32'h00010203;

   logic        clk;
   logic        rst_n;
   logic        pix_valid;
   logic        pix_ready;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [7:0]  pix_color;
   logic        clr_start;
   logic [7:0]  clr_color;
   logic        clr_done;
   logic        busy;
   logic [15:0] drop_cnt;
   logic [16:0] ram_adr;
   logic        ram_we;
   logic [31:0] ram_wdat;
   logic [31:0] ram_rdat;

   fb_pixel_writer #(.H_VIS(H), .V_VIS(V), .ADR_W(17)) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
      .clr_start(clr_start), .clr_color(clr_color),
      .clr_done(clr_done), .busy(busy), .drop_cnt(drop_cnt),
      .ram_adr(ram_adr), .ram_we(ram_we),
      .ram_wdat(ram_wdat), .ram_rdat(ram_rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          c;
      int          a;
      logic [31:0] d;
   } wr_t;

   logic [31:0] mem [int];
   wr_t         wq [$];
   int          acc_q [$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          bad_adr = 0;
   int          checks = 0;
   int          errors = 0;

   // Synchronous-read RAM returning the pre-write word
   always @(posedge clk) begin
      ram_rdat <= mem.exists(int'(ram_adr)) ? mem[int'(ram_adr)] : PRE;
      if (ram_we) mem[int'(ram_adr)] = ram_wdat;
   end

   always @(posedge clk) begin
      if (ram_we) begin
         wq.push_back('{cyc, int'(ram_adr), ram_wdat});
         if (int'(ram_adr) >= NW) bad_adr <= bad_adr + 1;
      end
      if (pix_valid && pix_ready) acc_q.push_back(cyc);
      if (clr_done) done_cnt <= done_cnt + 1;
      cyc <= cyc + 1;
   end

   logic [31:0] rmem [int];
   int          rdrop = 0;

   function automatic logic [31:0] rd_mem(input int a);
      return mem.exists(a) ? mem[a] : PRE;
   endfunction

   function automatic logic [31:0] rrd(input int a);
      return rmem.exists(a) ? rmem[a] : PRE;
   endfunction

   task automatic model_pix(input int x, input int y, input logic [7:0] c);
      int a;
      int sh;
      logic [31:0] w;
      if (x >= H || y >= V) begin
         if (rdrop < 65535) rdrop++;
      end else begin
         a  = y * (H / 4) + x / 4;
         sh = (3 - x % 4) * 8;
         w  = rrd(a);
         w  = (w & ~(32'hFF << sh)) | (32'(c) << sh);
         rmem[a] = w;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_pix(input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] c, output int acc);
      int n;
      pix_x = x;
      pix_y = y;
      pix_color = c;
      pix_valid = 1'b1;
      n = 0;
      while (!pix_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!pix_ready) begin
         chk("ready_timeout", {31'b0, pix_ready}, 32'd1);
         pix_valid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      acc = cyc;
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, {31'b0, pix_ready}, 32'd1);
      chk({tag, "_we"}, {31'b0, ram_we}, 32'd0);
      chk({tag, "_adr"}, {15'b0, ram_adr}, 32'd0);
      chk({tag, "_wdat"}, ram_wdat, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, clr_done}, 32'd0);
      chk({tag, "_drop"}, {16'b0, drop_cnt}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      pix_valid = 1'b0;
      clr_start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rdrop = 0;
   endtask

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [7:0]  c;
      bit          wr;
      int          adr;
      logic [31:0] dat;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int acc;
      int acc2;
      int n;
      int bad;
      logic [9:0] rx;
      logic [9:0] ry;
      logic [7:0] rc;

      tbl[0] = '{10'd5,    10'd0,    8'hAA, 1'b1, 1,     32'h00AA0203};
      tbl[1] = '{10'd0,    10'd0,    8'h12, 1'b1, 0,     32'h12010203};
      tbl[2] = '{10'd639,  10'd479,  8'h77, 1'b1, 76799, 32'h00010277};
      tbl[3] = '{10'd2,    10'd2,    8'h5A, 1'b1, 320,   32'h00015A03};
      tbl[4] = '{10'd640,  10'd0,    8'h01, 1'b0, 0,     32'h0};
      tbl[5] = '{10'd0,    10'd480,  8'h02, 1'b0, 0,     32'h0};
      tbl[6] = '{10'd1023, 10'd1023, 8'h03, 1'b0, 0,     32'h0};

      rst_n = 1'b0;
      pix_valid = 1'b0;
      pix_x = '0;
      pix_y = '0;
      pix_color = '0;
      clr_start = 1'b0;
      clr_color = '0;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         wq.delete();
         send_pix(tbl[i].x, tbl[i].y, tbl[i].c, acc);
         if (tbl[i].wr) begin
            chk("busy_after_acc", {31'b0, busy}, 32'd1);
            chk("ready_after_acc", {31'b0, pix_ready}, 32'd0);
         end
         model_pix(int'(tbl[i].x), int'(tbl[i].y), tbl[i].c);
         repeat (6) @(negedge clk);
         chk("tbl_nwr", wq.size(), tbl[i].wr ? 32'd1 : 32'd0);
         if (tbl[i].wr && wq.size() > 0) begin
            chk("tbl_adr", wq[0].a, tbl[i].adr);
            chk("tbl_dat", wq[0].d, tbl[i].dat);
            chk("tbl_lat", wq[0].c - acc, 32'd3);
         end
      end
      chk("tbl_drop", {16'b0, drop_cnt}, 32'd3);

      // Back-to-back requests on one word
      wq.delete();
      pix_x = 10'd0;
      pix_y = 10'd1;
      pix_color = 8'h11;
      pix_valid = 1'b1;
      @(posedge clk);
      acc = cyc;
      @(negedge clk);
      pix_x = 10'd3;
      pix_color = 8'h44;
      n = 0;
      while (!pix_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      acc2 = cyc;
      @(negedge clk);
      pix_valid = 1'b0;
      model_pix(0, 1, 8'h11);
      model_pix(3, 1, 8'h44);
      repeat (6) @(negedge clk);
      chk("b2b_ready_low", n, 32'd3);
      chk("b2b_gap", acc2 - acc, 32'd4);
      chk("b2b_nwr", wq.size(), 32'd2);
      chk("b2b_word160", rd_mem(160), 32'h11010244);

      // Drops
      do_reset();
      wq.delete();
      chk("drop_rst", {16'b0, drop_cnt}, 32'd0);
      send_pix(10'd640, 10'd0, 8'h55, acc);
      send_pix(10'd0, 10'd480, 8'h66, acc);
      repeat (6) @(negedge clk);
      chk("drop_nwr", wq.size(), 32'd0);
      chk("drop_two", {16'b0, drop_cnt}, 32'd2);

`ifndef FB_PIXEL_WRITER_CLEAR_EN
      do_reset();
      pix_x = 10'd700;
      pix_y = 10'd5;
      pix_valid = 1'b1;
      repeat (65534) @(negedge clk);
      chk("drop_fffe", {16'b0, drop_cnt}, 32'h0000FFFE);
      repeat (3) @(negedge clk);
      pix_valid = 1'b0;
      chk("drop_sat", {16'b0, drop_cnt}, 32'h0000FFFF);
      chk("drop_sat_nwr", wq.size(), 32'd0);
`endif

      // Random plotting against the word model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            rx = 10'($urandom_range(600, 1023));
         else
            rx = 10'($urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0)
            ry = 10'($urandom_range(470, 1023));
         else
            ry = 10'($urandom_range(0, 3));
         rc = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_pix(rx, ry, rc, acc);
         model_pix(int'(rx), int'(ry), rc);
      end
      repeat (6) @(negedge clk);
      foreach (rmem[a]) chk("rand_word", rd_mem(a), rmem[a]);
      chk("rand_drop", {16'b0, drop_cnt}, rdrop);

      // Reset during MRG
      wq.delete();
      send_pix(10'd20, 10'd7, 8'hC3, acc);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_outs("rst_mrg");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdrop = 0;
      repeat (6) @(negedge clk);
      chk("rst_mrg_nwr", wq.size(), 32'd0);

      // Reset during WR must drop ram_we without waiting for a clock
      send_pix(10'd24, 10'd7, 8'h3C, acc);
      @(posedge clk);
      @(posedge clk);
      #1 chk("wr_we_high", {31'b0, ram_we}, 32'd1);
      rst_n = 1'b0;
      #1 chk_reset_outs("rst_wr");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_wr_nwr", wq.size(), 32'd0);

      send_pix(10'd8, 10'd3, 8'h9C, acc);
      model_pix(8, 3, 8'h9C);
      repeat (6) @(negedge clk);
      chk("post_rst_nwr", wq.size(), 32'd1);
      chk("post_rst_word", rd_mem(3 * 160 + 2), rrd(3 * 160 + 2));

`ifdef FB_PIXEL_WRITER_CLEAR_EN
      do_reset();
      wq.delete();
      n = done_cnt;
      acc2 = acc_q.size();
      clr_color = 8'h3C;
      clr_start = 1'b1;
      pix_x = 10'd1;
      pix_y = 10'd1;
      pix_color = 8'hEE;
      pix_valid = 1'b1;
      #1 chk("clr_ready_low", {31'b0, pix_ready}, 32'd0);
      @(negedge clk);
      clr_start = 1'b0;
      pix_valid = 1'b0;
      bad = 0;
      while (!clr_done && bad < 80000) begin
         @(negedge clk);
         bad++;
      end
      chk("clr_done_seen", {31'b0, clr_done}, 32'd1);
      chk("clr_busy_low", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("clr_done_once", done_cnt - n, 32'd1);
      chk("clr_no_accept", acc_q.size() - acc2, 32'd0);
      chk("clr_nwr", wq.size(), NW);
      bad = 0;
      foreach (wq[i]) begin
         if (wq[i].a != i || wq[i].d != 32'h3C3C3C3C) bad++;
         if (i > 0 && wq[i].c != wq[i-1].c + 1) bad++;
      end
      chk("clr_words", bad, 32'd0);
      for (int a = 0; a < NW; a++) rmem[a] = 32'h3C3C3C3C;

      do_reset();
      wq.delete();
      clr_color = 8'h5A;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      bad = 0;
      while (wq.size() < 1000 && bad < 2000) begin
         @(negedge clk);
         bad++;
      end
      rst_n = 1'b0;
      #1 chk_reset_outs("rst_clr");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_clr_nwr", wq.size(), 32'd1000);
      for (int a = 0; a < 1000; a++) rmem[a] = 32'h5A5A5A5A;
      send_pix(10'd5, 10'd0, 8'h66, acc);
      model_pix(5, 0, 8'h66);
      repeat (6) @(negedge clk);
      chk("post_clr_word", rd_mem(1), 32'h5A665A5A);
`endif

      chk("adr_range", bad_adr, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
